// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings, clog2 and bit-timing derivation.
// Used by the receiver; intended for reuse by a future transmitter.
`default_nettype none

package uart_defs;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Narrowest counter that still holds at least one bit.
  function automatic int counter_width(input int max_count);
    int w;
    w = clog2(max_count);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to 1.
// Shared with the push-button input path.
`default_nettype none

module bit_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= {WIDTH{1'b1}};
      sync_q <= {WIDTH{1'b1}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_char_receiver.sv
// 8N1 UART receiver presenting each good byte as character_id plus a one-cycle we strobe.
// Optional 8E1 parity checking is enabled by defining UART_RX_PARITY_EN.
`default_nettype none

module uart_char_receiver
  import uart_defs::*;
#(
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD_RATE      = 9600,
  parameter int CHAR_ID_LENGTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic [CHAR_ID_LENGTH-1:0] character_id,
  output logic                      we,
  output logic                      frame_error,
  output logic                      busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
  localparam int CNT_W        = counter_width(CLKS_PER_BIT);
  localparam int IDX_W        = counter_width(CHAR_ID_LENGTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(CHAR_ID_LENGTH - 1);

  logic rx_s;

  logic [2:0]                state_q,  state_d;
  logic [CNT_W-1:0]          cnt_q,    cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic [CHAR_ID_LENGTH-1:0] shift_q,  shift_d;
  logic [CHAR_ID_LENGTH-1:0] char_q,   char_d;
  logic                      we_q,     we_d;
  logic                      fe_q,     fe_d;
  logic                      par_err;

  bit_synchronizer #(
    .WIDTH (1)
  ) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    char_d    = char_q;
    we_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (par_err) begin
              fe_d = 1'b1;
            end else begin
              char_d = shift_q;
              we_d   = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      char_q    <= '0;
      we_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      char_q    <= char_d;
      we_q      <= we_d;
      fe_q      <= fe_d;
    end
  end

  assign character_id = char_q;
  assign we           = we_q;
  assign frame_error  = fe_q;
  assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_char_receiver.sv
// Directed scoreboard bench for uart_char_receiver at CLKS_PER_BIT = 10.
`default_nettype none

module tb_uart_char_receiver;

  localparam int BIT = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int EXP_LAT = PAR_EN ? 108 : 98;

  localparam int K_WE = 1;
  localparam int K_FE = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] character_id;
  logic       we;
  logic       frame_error;
  logic       busy;

  int   cyc;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  uart_char_receiver #(
    .CLK_FREQ       (1000),
    .BAUD_RATE      (100),
    .CHAR_ID_LENGTH (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .character_id (character_id),
    .we           (we),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (we || frame_error) begin
      check("strobe_overlap", {31'd0, we & frame_error}, 32'd0);
      check("strobe_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        lat = cyc - e.start_cyc;
        check("strobe_kind", we ? K_WE : K_FE, e.kind);
        if (we) check("character_id", {24'd0, character_id}, {24'd0, e.data});
        check("latency_in_window", {31'd0, (lat >= EXP_LAT - 1) && (lat <= EXP_LAT + 1)}, 32'd1);
      end
    end
  end

  // Drives one frame starting at the next falling clock edge; the stop bit is
  // held for BIT-1 more cycles so a following call starts with no gap.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_bit, input int kind);
    exp_t e;
    @(negedge clk);
    if (kind != 0) begin
      e.kind      = kind;
      e.data      = data;
      e.start_cyc = cyc;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par_bit;
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT - 1) @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    rx       = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_character_id", {24'd0, character_id}, 32'd0);
    check("reset_we", {31'd0, we}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte; even parity bit for 0x41 is 0.
    send_frame(8'h41, 1'b1, 1'b0, K_WE);
    repeat (20) @(negedge clk);
    check("hold_0x41", {24'd0, character_id}, 32'h41);
    check("idle_after_0x41", {31'd0, busy}, 32'd0);

    // Back-to-back bytes with no idle gap.
    send_frame(8'h0D, 1'b1, 1'b1, K_WE);
    send_frame(8'h7E, 1'b1, 1'b0, K_WE);
    repeat (20) @(negedge clk);
    check("hold_0x7E", {24'd0, character_id}, 32'h7E);

    // Short low glitch must be rejected at the start-bit midpoint.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    busy_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("glitch_busy_le7", {31'd0, busy_cycles <= 7}, 32'd1);
    check("glitch_busy_seen", {31'd0, busy_cycles > 0}, 32'd1);
    check("glitch_idle", {31'd0, busy}, 32'd0);

    // Stop bit low, then a long break.
    send_frame(8'h55, 1'b0, 1'b0, K_FE);
    repeat (290) @(negedge clk);
    check("break_keeps_char", {24'd0, character_id}, 32'h7E);
    check("break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_released", {31'd0, busy}, 32'd0);
    send_frame(8'h31, 1'b1, 1'b1, K_WE);
    repeat (20) @(negedge clk);
    check("hold_0x31", {24'd0, character_id}, 32'h31);

    // Reset in the middle of data bit 4 of 0xFF: nothing may be emitted.
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT + 5) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midframe_reset_busy", {31'd0, busy}, 32'd0);
    check("midframe_reset_char", {24'd0, character_id}, 32'd0);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("after_reset_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h20, 1'b1, 1'b1, K_WE);
    repeat (20) @(negedge clk);
    check("hold_0x20", {24'd0, character_id}, 32'h20);

    if (PAR_EN) begin
      send_frame(8'h03, 1'b1, 1'b0, K_WE);
      repeat (20) @(negedge clk);
      check("parity_good_0x03", {24'd0, character_id}, 32'h03);
      send_frame(8'h5A, 1'b1, 1'b1, K_FE);
      repeat (20) @(negedge clk);
      send_frame(8'h03, 1'b1, 1'b1, K_FE);
      repeat (20) @(negedge clk);
      check("parity_bad_keeps_char", {24'd0, character_id}, 32'h03);
      check("parity_bad_idle", {31'd0, busy}, 32'd0);
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
